// File: rtl/des_key_schedule_if.sv
// Key-schedule handshake bundle: load request from the control side,
// subkey stream back to the DES round core.
interface des_key_schedule_if;
  logic        start;
  logic        mode;
  logic [0:63] key;
  logic        kready;
  logic        kvalid;
  logic [0:47] subkey;
  logic [3:0]  round_idx;
  logic        busy;
  logic        done;

  modport master (
    output start, mode, key, kready,
    input  kvalid, subkey, round_idx, busy, done
  );

  modport slave (
    input  start, mode, key, kready,
    output kvalid, subkey, round_idx, busy, done
  );
endinterface

// File: rtl/des_key_schedule.sv
// DES key schedule: PC-1 on load, then one rotated C/D pair per accepted beat,
// subkey is PC-2 of the registered C/D so it is valid the cycle kvalid rises.
module des_key_schedule #(
  parameter int NROUNDS = 16
) (
  input  logic              clk,
  input  logic              reset,
  des_key_schedule_if.slave kif
);

  typedef enum logic [1:0] {IDLE, GEN, FIN} state_t;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [0:55] pc1(input logic [0:63] k);
    logic [0:55] r;
    for (int i = 0; i < 56; i++) r[i] = k[PC1[i]-1];
    return r;
  endfunction

  function automatic logic [0:47] pc2(input logic [0:55] cd);
    logic [0:47] r;
    for (int i = 0; i < 48; i++) r[i] = cd[PC2[i]-1];
    return r;
  endfunction

  // Bit 0 is the leftmost (most significant) bit of each 28-bit half.
  function automatic logic [0:27] rotl(input logic [0:27] v, input logic one);
    return one ? {v[1:27], v[0]} : {v[2:27], v[0:1]};
  endfunction

  function automatic logic [0:27] rotr(input logic [0:27] v, input logic one);
    return one ? {v[27], v[0:26]} : {v[26:27], v[0:25]};
  endfunction

  state_t      state_q, state_d;
  logic [0:27] c_q, c_d, d_q, d_d;
  logic [3:0]  idx_q, idx_d;
  logic        mode_q, mode_d;
  logic [0:55] cd0;
  logic        shift1;

  assign cd0 = pc1(kif.key);
  // Single-bit shifts fall on the transitions leaving idx 0, 7 and 14 in both
  // directions: rounds 2/9/16 forward, and 16->15, 9->8, 2->1 backward.
  assign shift1 = (idx_q == 4'd0) || (idx_q == 4'd7) || (idx_q == 4'd14);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      idx_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    c_d           = c_q;
    d_d           = d_q;
    idx_d         = idx_q;
    mode_d        = mode_q;
    kif.kvalid    = 1'b0;
    kif.busy      = 1'b0;
    kif.done      = 1'b0;
    kif.round_idx = idx_q;
    kif.subkey    = pc2({c_q, d_q});
    case (state_q)
      IDLE: begin
        if (kif.start) begin
          mode_d  = kif.mode;
          idx_d   = 4'd0;
          state_d = GEN;
          // Encryption starts at C1/D1; decryption's first key uses C16 = C0.
          if (kif.mode) begin
            c_d = cd0[0:27];
            d_d = cd0[28:55];
          end else begin
            c_d = rotl(cd0[0:27], 1'b1);
            d_d = rotl(cd0[28:55], 1'b1);
          end
        end
      end
      GEN: begin
        kif.kvalid = 1'b1;
        kif.busy   = 1'b1;
        if (kif.kready) begin
          if (idx_q == 4'(NROUNDS - 1)) begin
            idx_d   = 4'd0;
            state_d = FIN;
          end else begin
            idx_d = idx_q + 4'd1;
            if (mode_q) begin
              c_d = rotr(c_q, shift1);
              d_d = rotr(d_q, shift1);
            end else begin
              c_d = rotl(c_q, shift1);
              d_d = rotl(d_q, shift1);
            end
          end
        end
      end
      FIN: begin
        kif.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
